counter_ctrl: RTL and testbench

Run-control sequencer for the team's 8-bit free-running counter datapath. It turns the bare count into a programmable interval timer with start/abort/pause control, terminal-count detection, one-shot or auto-reload modes and a completion pulse. It sits between a host control FSM and any logic that needs timed intervals, and exposes the live count for observation in benches.

---
 rtl/counter_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_counter_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// counter_ctrl: run-control sequencer turning an 8-bit counter into a programmable interval timer.
// Latency: start accepted on edge N -> busy=1, cnt=0 after N; all outputs registered, no input-to-output path.
// Backpressure: none; start is ignored while busy, abort/pause act on the next edge.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset (reset wins over everything)
//   start, mode, term launch request, 0=one-shot/1=auto-reload, terminal count (captured on start)
//   pause, abort      level freeze of counting, cancel of a run in progress
//   cnt, busy, done   live count, RUN/PAUSE indicator, one-cycle terminal-count pulse
//   periods           completed periods since last start, saturating at 255
//
// Build option: define COUNTER_CTRL_PRESCALE_EN to insert a PRESCALE-cycle tick prescaler;
// without it every RUN cycle is a tick and PRESCALE is only range-checked.

module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic [7:0]       periods
);

  // Elaboration-time guard on the prescaler range.
  if (PRESCALE < 2 || PRESCALE > 256) begin : g_prescale_range
    $error("counter_ctrl: PRESCALE must be in 2..256");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] term_q;
  logic             mode_q;

  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] term_nxt;
  logic             mode_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [7:0]       periods_nxt;

  logic             accept;
  logic             at_term;
  logic             tick;

  // A start only counts when abort is low in the same cycle.
  assign accept  = start & ~abort;
  assign at_term = (cnt == term_q);

`ifdef COUNTER_CTRL_PRESCALE_EN
  localparam int               PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_nxt;

  assign tick = (pre_q == PRE_LAST);

  // Prescaler only advances in RUN cycles that are neither paused nor aborted,
  // so a pause freezes the phase exactly where it was.
  always_comb begin
    pre_nxt = pre_q;
    if (state == S_IDLE) begin
      if (accept) begin
        pre_nxt = '0;
      end
    end else if (state == S_RUN && !abort && !pause) begin
      pre_nxt = tick ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_nxt;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic: abort > pause > tick
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (pause) begin
          state_nxt = S_PAUSE;
        end else if (tick && at_term && !mode_q) begin
          state_nxt = S_IDLE;
        end
      end
      S_PAUSE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (!pause) begin
          state_nxt = S_RUN;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic: next values for the registered outputs
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_nxt     = cnt;
    term_nxt    = term_q;
    mode_nxt    = mode_q;
    done_nxt    = 1'b0;
    periods_nxt = periods;

    case (state)
      S_IDLE: begin
        if (accept) begin
          term_nxt    = term;
          mode_nxt    = mode;
          cnt_nxt     = '0;
          periods_nxt = 8'd0;
        end
      end
      S_RUN: begin
        if (abort) begin
          cnt_nxt = '0;
        end else if (!pause && tick) begin
          if (at_term) begin
            done_nxt = 1'b1;
            if (periods != 8'hFF) begin
              periods_nxt = periods + 8'd1;
            end
            // One-shot leaves cnt parked on the terminal value.
            if (mode_q) begin
              cnt_nxt = '0;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (abort) begin
          cnt_nxt = '0;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      periods <= 8'd0;
    end else begin
      cnt     <= cnt_nxt;
      term_q  <= term_nxt;
      mode_q  <= mode_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      periods <= periods_nxt;
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: scoreboard bench for counter_ctrl.
// Each driven cycle pushes the expected outputs, popped and compared after the edge.
// Directed landmarks (done position, hold values) are also checked against constants.

module tb_counter_ctrl;

  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] term;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] cnt;
  logic             busy;
  logic             done;
  logic [7:0]       periods;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .term    (term),
    .pause   (pause),
    .abort   (abort),
    .cnt     (cnt),
    .busy    (busy),
    .done    (done),
    .periods (periods)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic [7:0] periods;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (0 = IDLE, 1 = RUN, 2 = PAUSE)
  int         m_state;
  logic [7:0] m_cnt;
  logic [7:0] m_term;
  logic [7:0] m_periods;
  logic       m_mode;
  logic       m_done;
`ifdef COUNTER_CTRL_PRESCALE_EN
  int         m_pre;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic tk;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_done = 0; m_periods = 0; m_term = 0; m_mode = 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      m_pre = 0;
`endif
    end else begin
      m_done = 0;
      case (m_state)
        0: begin
          if (start && !abort) begin
            m_term = term; m_mode = mode; m_cnt = 0; m_periods = 0; m_state = 1;
`ifdef COUNTER_CTRL_PRESCALE_EN
            m_pre = 0;
`endif
          end
        end
        1: begin
          if (abort) begin
            m_state = 0; m_cnt = 0;
          end else if (pause) begin
            m_state = 2;
          end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
            tk = (m_pre == PRESCALE - 1);
            m_pre = tk ? 0 : m_pre + 1;
`else
            tk = 1'b1;
`endif
            if (tk) begin
              if (m_cnt == m_term) begin
                m_done = 1;
                if (m_periods != 8'd255) m_periods = m_periods + 8'd1;
                if (m_mode) m_cnt = 0;
                else        m_state = 0;
              end else begin
                m_cnt = m_cnt + 8'd1;
              end
            end
          end
        end
        default: begin
          if (abort) begin
            m_state = 0; m_cnt = 0;
          end else if (!pause) begin
            m_state = 1;
          end
        end
      endcase
    end
  endtask

  // Push expectation for the current inputs, clock once, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    model_step();
    e.cnt     = m_cnt;
    e.busy    = (m_state != 0);
    e.done    = m_done;
    e.periods = m_periods;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq({tag, ".cnt"},     cnt,     e.cnt);
    check_eq({tag, ".busy"},    busy,    e.busy);
    check_eq({tag, ".done"},    done,    e.done);
    check_eq({tag, ".periods"}, periods, e.periods);
  endtask

  task automatic launch(input logic [7:0] t, input logic md);
    term  = t;
    mode  = md;
    start = 1'b1;
    step("start");
    start = 1'b0;
  endtask

  initial begin
    int done_at;
    int n_done;

    rst = 1'b1; start = 1'b0; mode = 1'b0; term = '0; pause = 1'b0; abort = 1'b0;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    step("idle");
    check_eq("reset_cnt", cnt, 0);
    check_eq("reset_busy", busy, 0);

`ifndef COUNTER_CTRL_PRESCALE_EN
    // Reset in the middle of a run at cnt=5
    launch(8'd10, 1'b0);
    for (int k = 0; k < 5; k++) step("pre_rst");
    check_eq("midrun_cnt", cnt, 5);
    rst = 1'b1;
    step("rst_a");
    step("rst_b");
    rst = 1'b0;
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_periods", periods, 0);

    // One-shot, term=3; term change mid-run must not matter
    launch(8'd3, 1'b0);
    term = 8'd99;
    done_at = -1;
    for (int k = 1; k <= 20 && done_at < 0; k++) begin
      step("oneshot");
      if (done === 1'b1) done_at = k;
    end
    check_eq("os_done_edge", done_at, 4);
    check_eq("os_cnt", cnt, 3);
    check_eq("os_busy", busy, 0);
    check_eq("os_periods", periods, 1);
    step("os_hold");
    check_eq("os_hold_cnt", cnt, 3);
    check_eq("os_single_pulse", done, 0);

    // Auto-reload, term=2, with ignored start pulses carrying a different term
    launch(8'd2, 1'b1);
    n_done = 0;
    for (int k = 1; k <= 9; k++) begin
      start = (k % 4 == 0);
      term  = 8'd7;
      step("reload");
      if (done === 1'b1) n_done++;
    end
    start = 1'b0;
    check_eq("ar_done_count", n_done, 3);
    check_eq("ar_periods", periods, 3);
    check_eq("ar_cnt_wrap", cnt, 0);
    abort = 1'b1;
    step("ar_abort");
    abort = 1'b0;
    check_eq("ar_abort_busy", busy, 0);
    check_eq("ar_abort_periods", periods, 3);

    // Pause at cnt=4 for 4 cycles, then abort at cnt=7
    launch(8'd10, 1'b0);
    for (int k = 0; k < 4; k++) step("pa_run");
    pause = 1'b1;
    for (int k = 0; k < 4; k++) step("pa_hold");
    check_eq("pa_cnt", cnt, 4);
    check_eq("pa_busy", busy, 1);
    pause = 1'b0;
    step("pa_resume");
    step("pa_run2");
    check_eq("pa_resumed_cnt", cnt, 5);
    step("pa_run3");
    step("pa_run4");
    check_eq("pa_pre_abort", cnt, 7);
    abort = 1'b1;
    step("abort");
    abort = 1'b0;
    check_eq("abort_cnt", cnt, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    step("post_abort");
    check_eq("post_abort_done", done, 0);

    // term=0 auto-reload: done every cycle, periods saturates
    launch(8'd0, 1'b1);
    n_done = 0;
    for (int k = 0; k < 300; k++) begin
      step("t0");
      if (done === 1'b1) n_done++;
    end
    check_eq("t0_done_count", n_done, 300);
    check_eq("t0_periods_sat", periods, 255);
    abort = 1'b1;
    step("t0_abort");
    abort = 1'b0;

    // term=255 one-shot: done after 256 edges, no overflow
    launch(8'd255, 1'b0);
    done_at = -1;
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      step("t255");
      if (done === 1'b1) done_at = k;
    end
    check_eq("t255_done_edge", done_at, 256);
    check_eq("t255_cnt", cnt, 255);

    // start together with abort in IDLE is ignored
    term = 8'd5; start = 1'b1; abort = 1'b1;
    step("start_abort");
    start = 1'b0; abort = 1'b0;
    check_eq("sa_busy", busy, 0);
    check_eq("sa_cnt", cnt, 255);
    step("sa_idle");
`else
    // Prescaler build: term=1, one-shot
    launch(8'd1, 1'b0);
    for (int k = 0; k < 4; k++) step("ps_run");
    check_eq("ps_cnt_after4", cnt, 1);
    done_at = 4;
    for (int k = 5; k <= 40 && done_at == 4; k++) begin
      step("ps_run");
      if (done === 1'b1) done_at = k;
    end
    check_eq("ps_done_edge", done_at, 8);
    check_eq("ps_busy", busy, 0);

    // Pause freezes the prescaler phase: 2 run edges, pause 3, resume.
    launch(8'd1, 1'b0);
    step("pp_run");
    step("pp_run");
    pause = 1'b1;
    for (int k = 0; k < 3; k++) step("pp_hold");
    pause = 1'b0;
    step("pp_resume");
    check_eq("pp_cnt_frozen", cnt, 0);
    step("pp_run");
    step("pp_run");
    check_eq("pp_tick_phase", cnt, 1);
    for (int k = 0; k < 4; k++) step("pp_tail");
    check_eq("pp_done", done, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
